expr_stream_gen: RTL and testbench

//  Transmit side of the ASCII arithmetic-expression byte stream. It serializes a

---
 rtl/expr_pkg.sv | 19 +
 rtl/expr_char_enc.sv | 15 +
 rtl/expr_stream_gen.sv | 159 +++++++++++++++
 tb/tb_expr_stream_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared ASCII constants and state encoding for the expression byte stream
// producers and the expression recognizer.
package expr_pkg;

  localparam logic [7:0] CH_0   = 8'd48;
  localparam logic [7:0] CH_9   = 8'd57;
  localparam logic [7:0] CH_MUL = 8'd42;
  localparam logic [7:0] CH_ADD = 8'd43;

  localparam int MAX_TERMS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational BCD digit / operator to ASCII encoder; zero latency, no flow control.
// op_sel selects '*' when set, '+' otherwise; bcd is ignored for operators.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       i_is_op,
  input  logic       i_op_sel,
  input  logic [3:0] i_bcd,
  output logic [7:0] o_ascii
);

  assign o_ascii = i_is_op ? (i_op_sel ? CH_MUL : CH_ADD)
                           : (CH_0 + {4'b0000, i_bcd});

endmodule

// File: rtl/expr_stream_gen.sv
// Serializes a captured digit/operator request into one ASCII byte per valid/ready
// handshake; first byte one cycle after start, bytes and state held while ready is low.
module expr_stream_gen
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int IW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [IW-1:0]          n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [IW-1:0] W_MAXN = IW'(MAX_TERMS);
  localparam logic [IW-1:0] W_ONE  = IW'(1);

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_n;
  logic [4*MAX_TERMS-1:0] r_digits;
  logic [MAX_TERMS-2:0]   r_ops;
  logic [7:0]             r_out_byte;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_req_ok;
  logic [IW-1:0]          w_idx_nx;
  logic                   w_op_bit;
  logic [3:0]             w_reg_bcd;
  logic                   w_enc_is_op;
  logic                   w_enc_op_sel;
  logic [3:0]             w_enc_bcd;
  logic [7:0]             w_enc_byte;

  // Only lanes below n_terms are checked; digits above are don't-care.
  always_comb begin
    w_req_ok = (n_terms != '0) && (n_terms <= W_MAXN);
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((IW'(i) < n_terms) && (digits[4*i +: 4] > 4'd9)) begin
        w_req_ok = 1'b0;
      end
    end
  end

  assign w_idx_nx = r_idx + W_ONE;

  always_comb begin
    w_op_bit  = 1'b0;
    w_reg_bcd = 4'd0;
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (IW'(i) == r_idx) w_op_bit = r_ops[i];
    end
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (IW'(i) == w_idx_nx) w_reg_bcd = r_digits[4*i +: 4];
    end
  end

  // The encoder always produces the byte for the state being entered next.
  always_comb begin
    w_enc_is_op  = 1'b0;
    w_enc_op_sel = 1'b0;
    w_enc_bcd    = digits[3:0];
    case (r_state)
      DIGIT: begin
        w_enc_is_op  = 1'b1;
        w_enc_op_sel = w_op_bit;
      end
      OP:      w_enc_bcd = w_reg_bcd;
      default: w_enc_bcd = digits[3:0];
    endcase
  end

  expr_char_enc u_enc (
    .i_is_op  (w_enc_is_op),
    .i_op_sel (w_enc_op_sel),
    .i_bcd    (w_enc_bcd),
    .o_ascii  (w_enc_byte)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_n         <= '0;
      r_digits    <= '0;
      r_ops       <= '0;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            if (w_req_ok) begin
              r_digits    <= digits;
              r_ops       <= ops;
              r_n         <= n_terms;
              r_idx       <= '0;
              r_out_byte  <= w_enc_byte;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= DIGIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        DIGIT: begin
          if (out_ready) begin
            if (r_idx == r_n - W_ONE) begin
              r_out_valid <= 1'b0;
              r_out_byte  <= 8'h00;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_out_byte <= w_enc_byte;
              r_state    <= OP;
            end
          end
        end
        OP: begin
          if (out_ready) begin
            r_idx      <= w_idx_nx;
            r_out_byte <= w_enc_byte;
            r_state    <= DIGIT;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_byte  = r_out_byte;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_expr_stream_gen.sv
// Randomized bench for expr_stream_gen: reference byte strings built from the request,
// grammar check on the accepted stream, handshake-hold, reject, busy-ignore and reset cases.
module tb_expr_stream_gen;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [3:0]  n_terms;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  expr_stream_gen dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .n_terms   (n_terms),
    .digits    (digits),
    .ops       (ops),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Grammar digit (op digit)* over the first len accepted bytes.
  function automatic bit expr_ok(input int len);
    bit ok;
    ok = (len % 2) == 1;
    for (int k = 0; k < len; k++) begin
      if (k % 2 == 0) ok = ok && (rx_q[k] >= 8'd48) && (rx_q[k] <= 8'd57);
      else            ok = ok && ((rx_q[k] == 8'd42) || (rx_q[k] == 8'd43));
    end
    return ok;
  endfunction

  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3) == 0;
        default: out_ready = ($urandom % 3) != 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_byte", out_byte, prev_byte);
      end
      if (out_valid && out_ready) rx_q.push_back(out_byte);
      if (done) done_cnt++;
      if (err)  err_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
    end
  end

  task automatic run_req(input int n, input logic [31:0] d, input logic [6:0] o,
                         input int mode, input bit chk_lat, input bit poke);
    int cyc;
    int d0;
    int e0;
    bit got;
    ready_mode = mode;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'd48 + {4'd0, d[4*i +: 4]});
      if (i < n - 1) exp_q.push_back(o[i] ? 8'd42 : 8'd43);
    end
    rx_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1;
    n_terms = 4'(n);
    digits  = d;
    ops     = o;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n_terms = 4'($urandom);
    digits  = $urandom;
    ops     = 7'($urandom);
    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("first_vld", out_valid, 1);
      if (done) got = 1'b1;
      if (poke && cyc == 2) begin
        n_terms = 4'd2;
        digits  = 32'h0000_0011;
        ops     = 7'h7f;
        start   = 1'b1;
      end
      if (poke && cyc == 4) start = 1'b0;
    end
    chk("done_seen", got, 1);
    if (chk_lat) chk("latency", cyc, 2 * n);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_cnt", done_cnt - d0, 1);
    chk("err_none", err_cnt - e0, 0);
    chk("len", rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      chk("byte", rx_q[k], exp_q[k]);
      chk("recog", expr_ok(k + 1), (rx_q[k] >= 8'd48 && rx_q[k] <= 8'd57) ? 1 : 0);
    end
  endtask

  task automatic err_req(input int n, input logic [31:0] d);
    ready_mode = 0;
    @(posedge clk);
    #1;
    n_terms = 4'(n);
    digits  = d;
    ops     = 7'h00;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_vld", out_valid, 0);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_end", err, 0);
    chk("err_vld2", out_valid, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int rn;
    clr_n   = 1'b0;
    start   = 1'b0;
    n_terms = 4'd0;
    digits  = 32'h0;
    ops     = 7'h0;
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #3;
    clr_n = 1'b1;

    run_req(3, 32'h0000_0725, 7'b0000010, 0, 1'b1, 1'b0);
    run_req(3, 32'h0000_0725, 7'b0000010, 1, 1'b0, 1'b0);
    run_req(1, 32'h0000_0009, 7'h00, 0, 1'b1, 1'b0);
    run_req(8, 32'h9876_5432, 7'h55, 0, 1'b1, 1'b0);
    run_req(2, 32'hAAAA_AA34, 7'h7e, 0, 1'b1, 1'b0);

    err_req(0, 32'h0000_0001);
    err_req(9, 32'h0000_0001);
    err_req(3, 32'h0000_0A12);

    run_req(5, 32'h0004_1357, 7'h05, 0, 1'b1, 1'b1);

    // Abort a 5-term request on its third byte, then restart from term 0.
    ready_mode = 0;
    @(posedge clk);
    #1;
    n_terms = 4'd5;
    digits  = 32'h0001_2345;
    ops     = 7'h0f;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_vld", out_valid, 1);
    #1;
    clr_n = 1'b0;
    #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_byte", out_byte, 0);
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    run_req(3, 32'h0000_0618, 7'h01, 0, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      rn = $urandom_range(1, 8);
      rd = 32'h0;
      for (int i = 0; i < 8; i++) rd[4*i +: 4] = 4'($urandom_range(0, 9));
      run_req(rn, rd, 7'($urandom), 2, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
